edge_frame_capture: RTL and testbench
=====================================

# edge_frame_capture

Downstream consumer of the Sobel edge stream. It captures one full frame of 8-bit edge magnitudes into on-chip memory, with optional binarisation and edge counting. It then replays the stored frame in raster order over a valid/ready output stream for readout (UART, display or testbench dump). It sits between the edge-detection top level and any slow sink that cannot accept one pixel per clock.

## Interface

- `WIDTH`, 64, pixels per line
- `HEIGHT`, 64, lines per frame
- `THRESH`, 8'd100, binarisation threshold (used only with `EDGE_BINARIZE_EN`)
- `clk` input 1: single clock, all logic on rising edge
- `rst` input 1: synchronous, active-high reset
- `start` input 1: single-cycle request to arm a capture
- `in_valid` input 1: `in_pixel` is a valid edge pixel this cycle
- `in_pixel` input 8: edge magnitude, raster order
- `busy` output 1: high in every state except IDLE
- `done` output 1: one-cycle pulse after the last readout pixel is accepted
- `out_valid` output 1: `out_pixel` is valid
- `out_ready` input 1: sink accepts `out_pixel` when high with `out_valid`
- `out_pixel` output 8: stored pixel, raster order
- `out_last` output 1: high with the final pixel of the frame
- `edge_count` output AW+1: edge pixels in the last captured frame, where AW = $clog2(WIDTH*HEIGHT)

## Operation

- Memory holds WIDTH*HEIGHT bytes. It has one synchronous write port and one synchronous read port, and read data appears 1 cycle after the address.
- State machine: IDLE, CAPTURE, READOUT, DONE.
- **IDLE**
  - `start`=1 moves to CAPTURE.
  - `wr_addr` and `edge_count` clear to 0.
  - `in_valid` is ignored.
- **CAPTURE**
  - Each cycle with `in_valid`=1 writes the stored value at `wr_addr` and increments `wr_addr`.
  - Cycles with `in_valid`=0 stall without writing.
  - The write at `wr_addr` = WIDTH*HEIGHT-1 moves to READOUT on the next cycle.
- **READOUT**
  - `rd_addr` starts at 0 and a prefetch register holds the next word.
  - `out_pixel`, `out_valid` and `out_last` are registered outputs.
  - Handshake transfer occurs on `out_valid` && `out_ready`.
  - While `out_valid`=1 and `out_ready`=0, `out_pixel` and `out_last` are held stable.
  - `out_valid` never drops without a transfer.
  - The transfer with `out_last`=1 moves to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then the block returns to IDLE.
- `start` outside IDLE is ignored. There is no queuing.
- `in_valid` outside CAPTURE is ignored and the memory is not written.
- `edge_count` increments during CAPTURE for each accepted pixel that counts as an edge (see Configuration). It never wraps: the maximum is WIDTH*HEIGHT, and the width covers it.
- `edge_count` holds its value through READOUT, DONE and IDLE until the next `start` clears it.
- `rst` in any state:
  - the next state is IDLE;
  - `busy`, `done`, `out_valid` and `out_last` are 0;
  - `out_pixel`, `edge_count`, `wr_addr` and `rd_addr` are 0;
  - memory contents are not cleared.

## Timing

- Reset values: every output is 0.
- `start` sampled in cycle N: `busy`=1 from N+1, and the first `in_valid` accepted is in cycle N+1.
- Capture throughput is 1 pixel per clock. A frame with no stalls takes WIDTH*HEIGHT cycles in CAPTURE.
- First `out_valid` occurs 2 cycles after entering READOUT: 1 cycle for the address and 1 for read data.
- With `out_ready` held high, one pixel transfers per clock with no bubbles. The full readout is WIDTH*HEIGHT+2 cycles.
- `out_ready` deasserting for K cycles adds exactly K cycles, and no pixel is dropped or duplicated.
- `done` rises the cycle after the `out_last` transfer. `busy` falls in the same cycle that `done` falls.
- `edge_count` is final from the cycle after the last capture write.

## Configuration

- Macro: `EDGE_BINARIZE_EN`.
- **Defined:**
  - the stored value is 8'hFF if `in_pixel` >= `THRESH`, otherwise 8'h00;
  - `edge_count` counts pixels with `in_pixel` >= `THRESH`.
- **Undefined:**
  - `in_pixel` is stored unmodified;
  - `edge_count` counts pixels with `in_pixel` != 0;
  - `THRESH` is unused.

## Test plan

- **Ramp frame, no stalls.** Stimulus: `start`, then WIDTH*HEIGHT pixels with value = addr[7:0] and `out_ready`=1. Expected: readout equals the input exactly, `out_last` is on pixel 4095 and `done` pulses once; without `EDGE_BINARIZE_EN`, `edge_count`=4080.
- **Binarize.** Stimulus: with `EDGE_BINARIZE_EN`, alternating pixels 99 and 100. Expected: readout alternates 00 and FF, and `edge_count`=2048.
- **Input stalls.** Stimulus: `in_valid` toggles every cycle during CAPTURE. Expected: the captured frame matches with no gaps and the state changes only after the 4096th valid pixel.
- **Backpressure.** Stimulus: random `out_ready` (e.g. 30% low). Expected: `out_pixel` is stable while stalled, 4096 transfers occur in order and there are no duplicates.
- **Ignored inputs.** Stimulus: `start` asserted during CAPTURE and READOUT; `in_valid` pulses in IDLE. Expected: no restart, memory unchanged and `edge_count` unchanged.
- **Reset mid-READOUT.** Stimulus: `rst` asserted after 100 transfers. Expected: next cycle all outputs are 0 and the state is IDLE; a new `start` and frame capture normally.

Source files
------------

// File: rtl/edge_frame_capture_if.sv
//------------------------------------------------------------------------------
// Module   : edge_frame_capture_if
// Brief    : Capture-control, input pixel and readout stream bundle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface edge_frame_capture_if #(
    parameter int CW = 13
);
    logic          start;
    logic          in_valid;
    logic [7:0]    in_pixel;
    logic          busy;
    logic          done;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_pixel;
    logic          out_last;
    logic [CW-1:0] edge_count;

    modport master (
        output start, in_valid, in_pixel, out_ready,
        input  busy, done, out_valid, out_pixel, out_last, edge_count
    );

    modport slave (
        input  start, in_valid, in_pixel, out_ready,
        output busy, done, out_valid, out_pixel, out_last, edge_count
    );
endinterface

`default_nettype wire

// File: rtl/edge_frame_capture.sv
//------------------------------------------------------------------------------
// Module   : edge_frame_capture
// Brief    : Captures one frame of edge magnitudes, replays it over valid/ready.
//            Optional binarisation/threshold counting via EDGE_BINARIZE_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module edge_frame_capture #(
    parameter int         WIDTH  = 64,
    parameter int         HEIGHT = 64,
    parameter logic [7:0] THRESH = 8'd100
) (
    input wire clk,
    input wire rst,
    edge_frame_capture_if.slave bus
);

    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [AW-1:0] c_wr_last = AW'(DEPTH - 1);
    localparam logic [AW:0]   c_depth   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   c_rd_last = (AW + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_READOUT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [AW:0]     rd_addr_q, rd_addr_d;
    logic [AW:0]     edge_count_q, edge_count_d;
    logic            pf_valid_q, pf_valid_d;
    logic            pf_last_q, pf_last_d;
    logic [7:0]      pf_data_q;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [7:0]      out_pixel_q, out_pixel_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [7:0]      mem [DEPTH];

    logic            w_wr_en;
    logic            w_rd_en;
    logic            w_out_load;
    logic            w_xfer;
    logic            w_is_edge;
    logic [7:0]      w_wr_data;

`ifdef EDGE_BINARIZE_EN
    assign w_is_edge = (bus.in_pixel >= THRESH);
    assign w_wr_data = w_is_edge ? 8'hFF : 8'h00;
`else
    logic w_unused_thresh;
    assign w_unused_thresh = ^THRESH;
    assign w_is_edge = (bus.in_pixel != 8'd0);
    assign w_wr_data = bus.in_pixel;
`endif

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        edge_count_d = edge_count_q;
        pf_valid_d   = pf_valid_q;
        pf_last_d    = pf_last_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_pixel_d  = out_pixel_q;
        w_wr_en      = 1'b0;
        w_rd_en      = 1'b0;
        w_out_load   = 1'b0;
        w_xfer       = out_valid_q && bus.out_ready;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d      = ST_CAPTURE;
                    wr_addr_d    = '0;
                    rd_addr_d    = '0;
                    edge_count_d = '0;
                    pf_valid_d   = 1'b0;
                    pf_last_d    = 1'b0;
                    out_valid_d  = 1'b0;
                    out_last_d   = 1'b0;
                end
            end

            ST_CAPTURE: begin
                if (bus.in_valid) begin
                    w_wr_en   = !rst;
                    wr_addr_d = wr_addr_q + AW'(1);
                    if (w_is_edge) begin
                        edge_count_d = edge_count_q + (AW + 1)'(1);
                    end
                    if (wr_addr_q == c_wr_last) begin
                        state_d = ST_READOUT;
                    end
                end
            end

            ST_READOUT: begin
                // Output register refills from the prefetch word whenever it
                // is empty or being drained, so a held-high ready sees no bubbles.
                w_out_load = pf_valid_q && (!out_valid_q || bus.out_ready);
                if (w_out_load) begin
                    out_valid_d = 1'b1;
                    out_pixel_d = pf_data_q;
                    out_last_d  = pf_last_q;
                end else if (w_xfer) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end

                w_rd_en = (rd_addr_q < c_depth) && (!pf_valid_q || w_out_load);
                if (w_rd_en) begin
                    rd_addr_d  = rd_addr_q + (AW + 1)'(1);
                    pf_valid_d = 1'b1;
                    pf_last_d  = (rd_addr_q == c_rd_last);
                end else if (w_out_load) begin
                    pf_valid_d = 1'b0;
                    pf_last_d  = 1'b0;
                end

                if (w_xfer && out_last_q) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            edge_count_q <= '0;
            pf_valid_q   <= 1'b0;
            pf_last_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_pixel_q  <= 8'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            edge_count_q <= edge_count_d;
            pf_valid_q   <= pf_valid_d;
            pf_last_q    <= pf_last_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_pixel_q  <= out_pixel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Frame store: contents survive reset; the read register is the prefetch word.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem[wr_addr_q] <= w_wr_data;
        end
        if (w_rd_en) begin
            pf_data_q <= mem[rd_addr_q[AW-1:0]];
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_pixel  = out_pixel_q;
    assign bus.out_last   = out_last_q;
    assign bus.edge_count = edge_count_q;

endmodule

`default_nettype wire

// File: tb/tb_edge_frame_capture.sv
//------------------------------------------------------------------------------
// Module   : tb_edge_frame_capture
// Brief    : Randomised self-checking bench for edge_frame_capture.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_edge_frame_capture;

    localparam int DEPTH = 64 * 64;
    localparam int CW    = 13;

    localparam int PH_IDLE = 0;
    localparam int PH_CAP  = 1;
    localparam int PH_READ = 2;

    logic clk;
    logic rst;

    edge_frame_capture_if #(.CW(CW)) bus ();

    edge_frame_capture #(
        .WIDTH  (64),
        .HEIGHT (64),
        .THRESH (8'd100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp;
    int         n_fail;
    int         phase;
    int         rd_idx;
    int         stall_cnt;
    int         held_count;
    int         exp_count;
    bit         tb_active;
    bit         expect_done;
    bit         prev_stall;
    logic [7:0] prev_pixel;
    logic       prev_last;
    logic [7:0] last_pixel;
    logic [7:0] src       [DEPTH];
    logic [7:0] exp_frame [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] stored_val(input logic [7:0] p);
`ifdef EDGE_BINARIZE_EN
        return (p >= 8'd100) ? 8'hFF : 8'h00;
`else
        return p;
`endif
    endfunction

    function automatic int edge_of(input logic [7:0] p);
`ifdef EDGE_BINARIZE_EN
        return (p >= 8'd100) ? 1 : 0;
`else
        return (p != 8'd0) ? 1 : 0;
`endif
    endfunction

    // pattern 0: ramp, 1: alternating 99/100, 2: random with ~25% zeros
    task automatic build_frame(input int pat);
        exp_count = 0;
        for (int i = 0; i < DEPTH; i++) begin
            case (pat)
                0:       src[i] = 8'(i);
                1:       src[i] = (i % 2 == 0) ? 8'd99 : 8'd100;
                default: src[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            endcase
            exp_frame[i] = stored_val(src[i]);
            exp_count    = exp_count + edge_of(src[i]);
        end
    endtask

    task automatic idle_cycles(input int n, input bit stray);
        for (int k = 0; k < n; k++) begin
            bus.in_valid = 1'b0;
            bus.in_pixel = 8'($urandom);
            bus.start    = stray && ($urandom_range(0, 3) == 0);
            tick();
        end
        bus.start = 1'b0;
    endtask

    task automatic run_frame(input int pat, input int stall_mode, input int low_pct,
                             input bit stray, input int abort_after);
        int cyc;
        build_frame(pat);
        rd_idx    = 0;
        stall_cnt = 0;

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        phase = PH_CAP;
        check("busy_after_start", bus.busy, 1);

        for (int i = 0; i < DEPTH; i++) begin
            if (stall_mode == 1 && i > 0) idle_cycles(1, stray);
            if (stall_mode == 2) idle_cycles($urandom_range(0, 2), stray);
            bus.in_valid = 1'b1;
            bus.in_pixel = src[i];
            tick();
        end
        bus.in_valid = 1'b0;
        held_count = exp_count;
        phase = PH_READ;
        check("count_final", bus.edge_count, exp_count);

        cyc = 0;
        while (!bus.done && cyc < DEPTH * 5) begin
            if (abort_after > 0 && rd_idx >= abort_after) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                phase = PH_IDLE;
                held_count = 0;
                check("rst_busy", bus.busy, 0);
                check("rst_done", bus.done, 0);
                check("rst_out_valid", bus.out_valid, 0);
                check("rst_out_last", bus.out_last, 0);
                check("rst_out_pixel", bus.out_pixel, 0);
                check("rst_edge_count", bus.edge_count, 0);
                return;
            end
            bus.out_ready = ($urandom_range(0, 99) >= low_pct);
            bus.start     = stray && ($urandom_range(0, 15) == 0);
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        check("readout_cycles", cyc, DEPTH + 2 + stall_cnt);
        check("xfer_count", rd_idx, DEPTH);
        tick();
        phase = PH_IDLE;
        check("done_low_after", bus.done, 0);
        check("busy_low_after", bus.busy, 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall  = 1'b0;
            expect_done = 1'b0;
        end else if (tb_active) begin
            check("done", bus.done, expect_done);
            if (expect_done) check("busy_in_done", bus.busy, 1);
            expect_done = 1'b0;

            if (prev_stall) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_pixel", bus.out_pixel, prev_pixel);
                check("hold_last", bus.out_last, prev_last);
            end

            if (phase != PH_READ) begin
                check("out_valid_quiet", bus.out_valid, 0);
            end else if (bus.out_valid && bus.out_ready) begin
                if (rd_idx < DEPTH) begin
                    check("out_pixel", bus.out_pixel, exp_frame[rd_idx]);
                    check("out_last", bus.out_last, (rd_idx == DEPTH - 1) ? 1 : 0);
                    if (rd_idx == DEPTH - 1) begin
                        expect_done = 1'b1;
                        last_pixel  = bus.out_pixel;
                    end
                end else begin
                    check("extra_xfer", rd_idx, DEPTH - 1);
                end
                rd_idx++;
            end

            if (phase == PH_READ && bus.out_valid && !bus.out_ready) stall_cnt++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_pixel = bus.out_pixel;
            prev_last  = bus.out_last;

            check("busy", bus.busy, (phase == PH_IDLE) ? 0 : 1);
            if (phase != PH_CAP) check("edge_count_hold", bus.edge_count, held_count);
        end
    end

    initial begin
        n_cmp = 0; n_fail = 0; phase = PH_IDLE; rd_idx = 0; stall_cnt = 0;
        held_count = 0; exp_count = 0; tb_active = 1'b0; expect_done = 1'b0;
        prev_stall = 1'b0; prev_pixel = 8'd0; prev_last = 1'b0; last_pixel = 8'd0;
        rst = 1'b1;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_pixel = 8'd0; bus.out_ready = 1'b0;
        repeat (3) tick();
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_last", bus.out_last, 0);
        check("reset_out_pixel", bus.out_pixel, 0);
        check("reset_edge_count", bus.edge_count, 0);
        rst = 1'b0;
        tb_active = 1'b1;
        tick();

        // Ramp, no stalls anywhere
        run_frame(0, 0, 0, 1'b0, 0);
`ifdef EDGE_BINARIZE_EN
        check("ramp_edge_count", bus.edge_count, 2496);
`else
        check("ramp_edge_count", bus.edge_count, 4080);
`endif
        check("ramp_last_pixel", last_pixel, 8'hFF);

        // Alternating 99/100 with in_valid toggling every cycle
        run_frame(1, 1, 0, 1'b0, 0);
`ifdef EDGE_BINARIZE_EN
        check("alt_edge_count", bus.edge_count, 2048);
        check("alt_last_pixel", last_pixel, 8'hFF);
`else
        check("alt_edge_count", bus.edge_count, 4096);
        check("alt_last_pixel", last_pixel, 8'd100);
`endif

        // Random data, random input stalls and backpressure, stray starts
        run_frame(2, 2, 30, 1'b1, 0);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_pixel = 8'($urandom_range(1, 255));
            tick();
        end
        bus.in_valid = 1'b0;
        check("idle_count_hold", bus.edge_count, exp_count);
        check("idle_busy", bus.busy, 0);

        // Reset in the middle of readout, then a clean frame
        run_frame(2, 0, 30, 1'b0, 100);
        tick();
        run_frame(2, 2, 30, 1'b0, 0);
        check("post_rst_count", bus.edge_count, exp_count);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
